// File: rtl/datapath_gen_pkg.sv
// Shared constants for the square-root datapath: ALU opcodes and status-flag bit indices.
package datapath_gen_pkg;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_SHR   = 3'b100;
   localparam logic [2:0] ALU_SHL   = 3'b101;
   localparam logic [2:0] ALU_PASSA = 3'b110;
   localparam logic [2:0] ALU_PASSB = 3'b111;

   localparam int unsigned FLAG_ZERO  = 0;
   localparam int unsigned FLAG_NEG   = 1;
   localparam int unsigned FLAG_CARRY = 2;
   localparam int unsigned NUM_FLAGS  = 3;

endpackage : datapath_gen_pkg

// File: rtl/regfile_gen.sv
// Register file: one write port, two combinational read ports, async active-high reset.
// Write-through forwarding of the external operand is enabled by DATAPATH_GEN_BYPASS_EN.
module regfile_gen
   import datapath_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  byp_en_i,
   input  logic [DATA_WIDTH-1:0] byp_data_i,
   input  logic [ADDR_WIDTH-1:0] raddr_a_i,
   input  logic [ADDR_WIDTH-1:0] raddr_b_i,
   output logic [DATA_WIDTH-1:0] rdata_a_o,
   output logic [DATA_WIDTH-1:0] rdata_b_o
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

`ifdef DATAPATH_GEN_BYPASS_EN
   // Forward only the external operand; forwarding the ALU result would close a loop.
   always_comb begin
      rdata_a_o = mem_q[raddr_a_i];
      rdata_b_o = mem_q[raddr_b_i];
      if (byp_en_i && (waddr_i == raddr_a_i)) begin
         rdata_a_o = byp_data_i;
      end
      if (byp_en_i && (waddr_i == raddr_b_i)) begin
         rdata_b_o = byp_data_i;
      end
   end
`else
   logic unused_byp;

   assign rdata_a_o  = mem_q[raddr_a_i];
   assign rdata_b_o  = mem_q[raddr_b_i];
   assign unused_byp = byp_en_i ^ (^byp_data_i);
`endif

endmodule : regfile_gen

// File: rtl/datapath_gen.sv
// Square-root datapath: register file, write-source mux, eight-op ALU, registered flags
// and a valid/ready output holding register. Optional forwarding: DATAPATH_GEN_BYPASS_EN.
module datapath_gen
   import datapath_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 8,
   parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  IE,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] ADDR_WR,
   input  logic [ADDR_WIDTH-1:0] ADDR_RDA,
   input  logic [ADDR_WIDTH-1:0] ADDR_RDB,
   input  logic [2:0]            ALU_Op,
   input  logic                  OE,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  out_valid_o,
   output logic                  oe_drop_o,
   output logic                  zero_o,
   output logic                  negative_o,
   output logic                  carry_o
);

   localparam int unsigned SHW = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] rd_a;
   logic [DATA_WIDTH-1:0] rd_b;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  alu_carry;
   logic [DATA_WIDTH:0]   alu_wide;
   logic [SHW-1:0]        shamt;

   logic [NUM_FLAGS-1:0]  flags_d;
   logic [NUM_FLAGS-1:0]  flags_q;
   logic                  flags_en;

   logic [DATA_WIDTH-1:0] data_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_d;
   logic                  valid_q;
   logic                  drop_d;
   logic                  drop_q;
   logic                  accept;

   assign wr_data = IE ? data_i : alu_res;

   regfile_gen #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .we_i       (WE),
      .waddr_i    (ADDR_WR),
      .wdata_i    (wr_data),
      .byp_en_i   (WE & IE),
      .byp_data_i (data_i),
      .raddr_a_i  (ADDR_RDA),
      .raddr_b_i  (ADDR_RDB),
      .rdata_a_o  (rd_a),
      .rdata_b_o  (rd_b)
   );

   assign shamt = rd_b[SHW-1:0];

   // ALU; carry is the extra bit of a zero-extended add/subtract (borrow for SUB).
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_wide  = '0;
      unique case (ALU_Op)
         ALU_ADD: begin
            alu_wide  = {1'b0, rd_a} + {1'b0, rd_b};
            alu_res   = alu_wide[DATA_WIDTH-1:0];
            alu_carry = alu_wide[DATA_WIDTH];
         end
         ALU_SUB: begin
            alu_wide  = {1'b0, rd_a} - {1'b0, rd_b};
            alu_res   = alu_wide[DATA_WIDTH-1:0];
            alu_carry = alu_wide[DATA_WIDTH];
         end
         ALU_AND:   alu_res = rd_a & rd_b;
         ALU_OR:    alu_res = rd_a | rd_b;
         ALU_SHR:   alu_res = rd_a >> shamt;
         ALU_SHL:   alu_res = rd_a << shamt;
         ALU_PASSA: alu_res = rd_a;
         ALU_PASSB: alu_res = rd_b;
         default:   alu_res = '0;
      endcase
   end

   // Flags track only ALU writebacks into the register file.
   always_comb begin
      flags_d             = flags_q;
      flags_en            = WE & ~IE;
      if (flags_en) begin
         flags_d[FLAG_ZERO]  = (alu_res == '0);
         flags_d[FLAG_NEG]   = alu_res[DATA_WIDTH-1];
         flags_d[FLAG_CARRY] = alu_carry;
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      drop_d  = drop_q;
      accept  = OE & (~valid_q | out_ready_i);
      if (accept) begin
         data_d  = alu_res;
         valid_d = 1'b1;
      end else if (out_ready_i && valid_q) begin
         valid_d = 1'b0;
      end
      if (OE && valid_q && !out_ready_i) begin
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         flags_q <= flags_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         drop_q  <= drop_d;
      end
   end

   assign data_o      = data_q;
   assign out_valid_o = valid_q;
   assign oe_drop_o   = drop_q;
   assign zero_o      = flags_q[FLAG_ZERO];
   assign negative_o  = flags_q[FLAG_NEG];
   assign carry_o     = flags_q[FLAG_CARRY];

endmodule : datapath_gen
